// File: rtl/rd_ptr_empty_if.sv
// rtl/rd_ptr_empty_if.sv - read-side pointer/empty bundle between FIFO read logic and its user
interface rd_ptr_empty_if #(
    parameter int W = 4
);
    logic         rinc;
    logic [W:0]   wptr_gray;
    logic [W-1:0] raddr;
    logic [W:0]   rptr_gray;
    logic         rempty;
    logic [W:0]   rcount;
    logic         runderflow;

    modport master (
        output rinc,
        output wptr_gray,
        input  raddr,
        input  rptr_gray,
        input  rempty,
        input  rcount,
        input  runderflow
    );

    modport slave (
        input  rinc,
        input  wptr_gray,
        output raddr,
        output rptr_gray,
        output rempty,
        output rcount,
        output runderflow
    );
endinterface

// File: rtl/rd_ptr_empty.sv
// rtl/rd_ptr_empty.sv - async FIFO read pointer, write-pointer synchronizer, empty flag and fill level
module rd_ptr_empty #(
    parameter int W = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    rd_ptr_empty_if.slave    bus
);
    logic [W:0] wq1;
    logic [W:0] wq2;
    logic [W:0] rbin;
    logic [W:0] rbin_next;
    logic [W:0] rgray_next;
    logic [W:0] wbin_s;
    logic       pop;

    // A pop is only honoured while not empty, so an underflow attempt leaves every pointer alone.
    always_comb begin
        pop        = bus.rinc & ~bus.rempty;
        rbin_next  = rbin + {{W{1'b0}}, pop};
        rgray_next = rbin_next ^ (rbin_next >> 1);
    end

    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= W; i++) begin
            wbin_s[i] = ^(wq2 >> i);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1            <= '0;
            wq2            <= '0;
            rbin           <= '0;
            bus.rptr_gray  <= '0;
            bus.rempty     <= 1'b1;
            bus.rcount     <= '0;
            bus.runderflow <= 1'b0;
        end else begin
            wq1            <= bus.wptr_gray;
            wq2            <= wq1;
            rbin           <= rbin_next;
            bus.rptr_gray  <= rgray_next;
            // Next-state compare lets the pop that drains the last entry flag empty on the same edge.
            bus.rempty     <= (rgray_next == wq2);
            bus.rcount     <= wbin_s - rbin_next;
            bus.runderflow <= bus.rinc & bus.rempty;
        end
    end

    assign bus.raddr = rbin[W-1:0];
endmodule

// File: tb/tb_rd_ptr_empty.sv
// tb/tb_rd_ptr_empty.sv - directed self-checking bench for rd_ptr_empty
module tb_rd_ptr_empty;
    localparam int W = 4;

    logic rclk;
    logic rrst;
    int   checks;
    int   errors;

    rd_ptr_empty_if #(.W(W)) bus ();

    rd_ptr_empty #(.W(W)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_raddr"}, 32'(bus.raddr), 0);
        check({tag, "_rptr_gray"}, 32'(bus.rptr_gray), 0);
        check({tag, "_rempty"}, 32'(bus.rempty), 1);
        check({tag, "_rcount"}, 32'(bus.rcount), 0);
        check({tag, "_runderflow"}, 32'(bus.runderflow), 0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rrst          = 1'b1;
        bus.rinc      = 1'b1;
        bus.wptr_gray = 5'b00101;
        tick(2);
        check_reset_state("reset");

        rrst          = 1'b0;
        bus.rinc      = 1'b0;
        bus.wptr_gray = 5'b00000;
        tick(1);
        check("idle_rempty", 32'(bus.rempty), 1);

        // synchronizer latency: three edges before the write pointer is seen
        bus.wptr_gray = 5'b00001;
        tick(1);
        check("sync_e1_rempty", 32'(bus.rempty), 1);
        tick(1);
        check("sync_e2_rempty", 32'(bus.rempty), 1);
        tick(1);
        check("sync_e3_rempty", 32'(bus.rempty), 0);
        check("sync_e3_rcount", 32'(bus.rcount), 1);

        bus.rinc = 1'b1;
        tick(1);
        bus.rinc = 1'b0;
        check("lastpop_raddr", 32'(bus.raddr), 1);
        check("lastpop_rptr_gray", 32'(bus.rptr_gray), 5'b00001);
        check("lastpop_rempty", 32'(bus.rempty), 1);
        check("lastpop_rcount", 32'(bus.rcount), 0);

        // underflow while empty
        bus.rinc = 1'b1;
        tick(1);
        check("uf1_runderflow", 32'(bus.runderflow), 1);
        check("uf1_raddr", 32'(bus.raddr), 1);
        check("uf1_rptr_gray", 32'(bus.rptr_gray), 5'b00001);
        tick(1);
        check("uf2_runderflow", 32'(bus.runderflow), 1);
        check("uf2_raddr", 32'(bus.raddr), 1);
        check("uf2_rempty", 32'(bus.rempty), 1);
        bus.rinc = 1'b0;
        tick(1);
        check("uf_end_runderflow", 32'(bus.runderflow), 0);
        check("uf_end_rptr_gray", 32'(bus.rptr_gray), 5'b00001);

        // wrap-around: start from rbin=0, write pointer binary 31
        rrst          = 1'b1;
        bus.wptr_gray = 5'b10000;
        tick(1);
        rrst = 1'b0;
        tick(3);
        check("wrap_rcount", 32'(bus.rcount), 31);
        check("wrap_rempty", 32'(bus.rempty), 0);
        bus.rinc = 1'b1;
        tick(31);
        bus.rinc = 1'b0;
        check("wrap31_raddr", 32'(bus.raddr), 15);
        check("wrap31_rptr_gray", 32'(bus.rptr_gray), 5'b10000);
        check("wrap31_rempty", 32'(bus.rempty), 1);
        check("wrap31_rcount", 32'(bus.rcount), 0);

        bus.wptr_gray = 5'b00010;
        tick(3);
        check("wrap3_rcount", 32'(bus.rcount), 4);
        check("wrap3_rempty", 32'(bus.rempty), 0);
        bus.rinc = 1'b1;
        tick(4);
        bus.rinc = 1'b0;
        check("wrap4_rptr_gray", 32'(bus.rptr_gray), 5'b00010);
        check("wrap4_raddr", 32'(bus.raddr), 3);
        check("wrap4_rempty", 32'(bus.rempty), 1);

        // full level: write pointer binary 16 against rbin=0
        rrst          = 1'b1;
        bus.wptr_gray = 5'b11000;
        tick(1);
        rrst = 1'b0;
        tick(3);
        check("full_rcount", 32'(bus.rcount), 16);
        check("full_rempty", 32'(bus.rempty), 0);

        // pop 11 to reach level 5, then reset mid-stream with rinc high
        bus.rinc = 1'b1;
        tick(11);
        check("mid_rcount", 32'(bus.rcount), 5);
        check("mid_raddr", 32'(bus.raddr), 11);
        rrst = 1'b1;
        tick(1);
        check_reset_state("midrst");
        rrst     = 1'b0;
        bus.rinc = 1'b0;
        tick(1);
        check("post_e1_rempty", 32'(bus.rempty), 1);
        tick(1);
        check("post_e2_rempty", 32'(bus.rempty), 1);
        check("post_e2_rcount", 32'(bus.rcount), 0);
        tick(1);
        check("post_e3_rempty", 32'(bus.rempty), 0);
        check("post_e3_rcount", 32'(bus.rcount), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
- Read-domain pointer and empty-flag stage of the asynchronous FIFO.
- Brings the write pointer in through a 2-flop synchronizer and keeps the read pointer as binary plus gray.
- Outputs: RAM read address, gray read pointer (for the write domain), registered empty flag and read-side fill level.
- Decodes the synchronized gray write pointer to binary internally, using the same (W+1)-bit gray-to-binary rule as the FIFO's gray decoder.

Parameters:
- W, 4, address width. FIFO depth = 2^W. Pointers are W+1 bits, the extra MSB being the wrap bit.

Ports:
- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst  input  1  synchronous, active-high reset, sampled on rising rclk.
- rinc  input  1  read request; pops one entry when rempty=0.
- wptr_gray  input  W+1  gray write pointer from the write domain, asynchronous to rclk.
- raddr  output  W  RAM read address = rbin[W-1:0].
- rptr_gray  output  W+1  registered gray read pointer, sent to the write-domain synchronizer.
- rempty  output  1  registered empty flag.
- rcount  output  W+1  registered fill level as seen by the read domain, 0..2^W.
- runderflow  output  1  registered one-cycle pulse on a read attempt while empty.

Behaviour:
- Synchronizer: wq1 <= wptr_gray; wq2 <= wq1. No logic between wptr_gray and wq1.
- Read pointer: rbin is a (W+1)-bit register.
  - rbin_next = rbin + (rinc & ~rempty), modulo 2^(W+1), so 2^(W+1)-1 wraps to 0.
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rbin <= rbin_next; rptr_gray <= rgray_next.
- Empty: rempty <= (rgray_next == wq2). It is computed from next-state values, so the pop that takes the last entry asserts rempty on the same edge.
- Level: wbin_s = gray-to-binary of wq2, where bit i = XOR of wq2 bits W..i. rcount <= (wbin_s - rbin_next) mod 2^(W+1).
- Underflow: runderflow <= rinc & rempty.
  - A read while empty does not move any pointer and does not change rempty.
- Latency:
  - A wptr_gray change that is stable before rclk edge N shows on rempty and rcount after edge N+2 (three edges total).
  - A pop updates raddr, rptr_gray, rempty and rcount on the same edge.
- Simultaneous pop and write-pointer arrival: both are folded into one evaluation; rempty and rcount use rgray_next/rbin_next against the current wq2.
- Reset: on a rising rclk edge with rrst=1, all registers take reset values and rinc is ignored.
  - rbin=0, rptr_gray=0, raddr=0, wq1=wq2=0, rempty=1, rcount=0, runderflow=0.
  - Reset is legal mid-stream. After release, a nonzero wptr_gray re-propagates through the synchronizer with the normal latency.
- Legality: wptr_gray changes at most one bit per write-clock edge. rcount never exceeds 2^W while the writer honours its full flag.
- Flags and pointers are glitch-free: every output is a flop output or a direct slice of one (raddr).

Test Plan (W=4):
- Reset: hold rrst=1 for 2 edges with rinc=1 and wptr_gray=00101 -> raddr=0, rptr_gray=00000, rempty=1, rcount=0, runderflow=0.
- Sync latency and last-entry pop:
  - Set wptr_gray=00001 (binary 1) -> rempty stays 1 for 2 edges, drops after the 3rd edge, rcount=1.
  - Then pulse rinc one cycle -> raddr=1, rptr_gray=00001, rempty=1, rcount=0 on the same edge.
- Underflow: rinc=1 for 2 cycles while empty -> rbin, rptr_gray and raddr unchanged; runderflow=1 for each of those cycles, then 0.
- Wrap-around:
  - Set wptr_gray=10000 (binary 31) and pop 31 times -> raddr=15, rptr_gray=10000, rempty=1.
  - Set wptr_gray=00010 (binary 3) -> rcount=4; pop 4 times -> rptr_gray=00010, raddr=3, rempty=1.
- Full-level count: rbin=0, wptr_gray=11000 (binary 16) -> rcount=10000 (16), rempty=0.
- Mid-stream reset: rcount=5, assert rrst for one edge with rinc=1 -> all outputs at reset values.
  - After release with wptr_gray held, rempty=0 and rcount equals the binary of the held wptr_gray on the 3rd post-release edge.
